// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM among NUM_REQ renderers and returns tagged data ROM_LAT cycles later.
// Define SPRITE_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 5,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [PTR_W-1:0] id_t;

  logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
  logic [ROM_LAT-1:0] vld_q, vld_d;
  id_t                id_q [ROM_LAT];
  id_t                id_d [ROM_LAT];

  logic               gnt_any;
  id_t                gnt_id;
  logic [ADDR_W-1:0]  gnt_addr;
  id_t                start_idx;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  id_t rr_ptr_q, rr_ptr_d;
  assign start_idx = rr_ptr_q;

  // Wrap is explicit because NUM_REQ need not be a power of two.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any)
      rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + id_t'(1);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`endif

  // Pass one takes requesters at or above the start index, pass two wraps to the rest.
  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt      = '0;
    gnt_any  = 1'b0;
    gnt_id   = '0;
    gnt_addr = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && req[i] && (id_t'(i) >= start_idx)) begin
          gnt_any  = 1'b1;
          gnt_id   = id_t'(i);
          gnt[i]   = 1'b1;
          gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!gnt_any && req[i]) begin
          gnt_any  = 1'b1;
          gnt_id   = id_t'(i);
          gnt[i]   = 1'b1;
          gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  always_comb begin
    last_addr_d = gnt_any ? gnt_addr : last_addr_q;
    rom_address = last_addr_d;
  end

  always_comb begin
    vld_d[0] = gnt_any;
    id_d[0]  = gnt_id;
    for (int s = 1; s < ROM_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  // NOTE: non-blocking in clocked blocks; only the valid bits need reset, ids are qualified by them.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vld_q       <= '0;
      last_addr_q <= '0;
    end else begin
      vld_q       <= vld_d;
      last_addr_q <= last_addr_d;
    end
  end

  always_ff @(posedge vga_clk) begin
    id_q <= id_d;
  end

  always_comb begin
    rsp_valid = '0;
    if (!reset && vld_q[ROM_LAT-1])
      rsp_valid[id_q[ROM_LAT-1]] = 1'b1;
  end

  assign rsp_data = rom_q;
  assign busy     = |vld_q;

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one synchronous single-port sprite ROM, clocked on vga_clk, among NUM_REQ render requesters (balloon, tower and projectile layers).
- Each cycle it grants at most one requester, drives the ROM address, and returns ROM data, tagged to the winner, exactly ROM_LAT cycles later.
- Sits between the per-layer sprite renderers and the sprite ROM/palette path, upstream of the final pixel mux.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_W, 17, ROM address width.
- DATA_W, 5, ROM word width (palette index).
- ROM_LAT, 1, cycles from address presented to valid rom_q (1..4).

Ports:
- vga_clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request, one bit per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rom_address  out  ADDR_W  address to the sprite ROM.
- rom_q  in  DATA_W  ROM read data.
- rsp_valid  out  NUM_REQ  one-hot: rsp_data belongs to requester i this cycle.
- rsp_data  out  DATA_W  ROM data returned to the requester.
- busy  out  1  high while any response is in flight.

Behaviour:
- Clocking and reset: one clock, vga_clk; reset is synchronous and active-high.
- Reset values:
  - rr_ptr = 0.
  - Response pipeline valid bits all 0, so rsp_valid = 0 and busy = 0.
  - last_addr register = 0.
  - rsp_data is don't-care while rsp_valid = 0; a bench must not check it.
- Arbitration (combinational):
  - Round-robin search starts at index rr_ptr and wraps modulo NUM_REQ.
  - The first i with req[i] = 1 gets gnt[i] = 1; all other gnt bits are 0.
  - If req = 0, gnt = 0.
  - While reset is high, gnt = 0.
- Pointer update: on a cycle with a grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Address:
  - With a grant, rom_address = req_addr of the granted requester, same cycle.
  - Otherwise rom_address = last_addr.
  - On a grant, last_addr <= granted address.
  - rom_address never glitches to an ungranted requester's address.
- Response pipeline:
  - Shift register of depth ROM_LAT holding {valid, id}.
  - Stage 0 loads {|gnt, granted id}.
  - At the last stage, rsp_valid[id] = valid and rsp_data = rom_q, passed through combinationally.
  - A grant in cycle T therefore gives rsp_valid in cycle T+ROM_LAT.
- Throughput:
  - One grant per cycle, back-to-back, with no bubbles.
  - With k requesters continuously requesting, each is granted once every k cycles.
- Requester handshake:
  - A requester holds req and req_addr stable until it sees gnt.
  - The grant is the acceptance: the requester may change its address or drop req the next cycle.
  - Dropping req before a grant is legal; no grant is issued to it and no state is affected.
- busy = OR of all pipeline valid bits.
- Boundaries:
  - All requesters high: strict rotation 0, 1, 2, 0, ...
  - A single requester high continuously: granted every cycle.
  - rr_ptr pointing at an idle requester: the search skips it; no wasted cycle.
  - Reset mid-operation: all in-flight responses are dropped; no rsp_valid is issued for them, even from the cycle after reset deasserts.
  - A grant issued in the same cycle that reset is high does not exist, because gnt is forced to 0.
- Width rules:
  - rr_ptr is $clog2(NUM_REQ) bits.
  - Wrap is computed explicitly, not by overflow, since NUM_REQ may be a non-power-of-2.

Optional Feature:
- Macro: SPRITE_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest requesting index always wins. rr_ptr is not implemented and is treated as 0. Starvation of higher indices is allowed. Latency and pipeline are unchanged.
- Undefined: round-robin behaviour as above.

Test Plan:
- Reset then idle: reset high 2 cycles, req=000 for 5 cycles -> gnt=000, rsp_valid=000, busy=0, rom_address=0 throughout.
- Single request, ROM_LAT=1: req=010 with addr1=0x00ABC for one cycle -> gnt=010 and rom_address=0x00ABC that cycle. Next cycle rsp_valid=010 and rsp_data = ROM contents at 0x00ABC. rom_address then holds 0x00ABC while idle.
- Full contention: req=111 held for 6 cycles from reset -> gnt sequence 001, 010, 100, 001, 010, 100. rsp_valid repeats that sequence delayed by ROM_LAT, each response with the matching address's data.
- Skip idle: rr_ptr=1 with req=101 -> gnt=100, then rr_ptr=0 -> next gnt=001. No empty cycle while any req is high.
- Reset mid-flight, ROM_LAT=3: grant at cycle T, reset high at T+1 for one cycle -> no rsp_valid at T+3. busy=0 from T+2.
- With SPRITE_ARB_FIXED_PRIO_EN defined: req=111 for 4 cycles -> gnt=001 every cycle. Then req=110 -> gnt=010.
